packet_dispatcher: RTL and testbench

//  1-to-2 demultiplexer for the IP header + 8-bit AXIS payload stream; the counterpart to the 2-to-1 packet arbiter.
//  It accepts one IP packet at a time and registers its header. It steers the header and payload to output 0 or 1

---
 rtl/packet_dispatcher.sv | 178 +++++++++++++++++
 tb/tb_packet_dispatcher.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_dispatcher.sv
// One-packet-at-a-time IP demultiplexer: registers the header, steers header and payload
// to output 0 or 1 by dest-IP subnet match, and counts delivered/errored packets.
module packet_dispatcher #(
    parameter logic [31:0] ROUTE_MASK  = 32'hFFFF_FF00,
    parameter logic [31:0] ROUTE_MATCH = 32'h0A00_0000,
    parameter int          CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_ip_hdr_valid,
    output logic                 i_ip_hdr_ready,
    input  logic [47:0]          i_ip_eth_dest_mac,
    input  logic [47:0]          i_ip_eth_src_mac,
    input  logic [15:0]          i_ip_eth_type,
    input  logic [3:0]           i_ip_version,
    input  logic [3:0]           i_ip_ihl,
    input  logic [5:0]           i_ip_dscp,
    input  logic [1:0]           i_ip_ecn,
    input  logic [15:0]          i_ip_length,
    input  logic [15:0]          i_ip_identification,
    input  logic [2:0]           i_ip_flags,
    input  logic [12:0]          i_ip_fragment_offset,
    input  logic [7:0]           i_ip_ttl,
    input  logic [7:0]           i_ip_protocol,
    input  logic [15:0]          i_ip_header_checksum,
    input  logic [31:0]          i_ip_source_ip,
    input  logic [31:0]          i_ip_dest_ip,
    input  logic [7:0]           i_ip_payload_axis_tdata,
    input  logic                 i_ip_payload_axis_tvalid,
    input  logic                 i_ip_payload_axis_tlast,
    input  logic                 i_ip_payload_axis_tuser,
    output logic                 i_ip_payload_axis_tready,
    output logic                 o_if0_ip_hdr_valid,
    input  logic                 o_if0_ip_hdr_ready,
    output logic [47:0]          o_if0_ip_eth_dest_mac,
    output logic [47:0]          o_if0_ip_eth_src_mac,
    output logic [15:0]          o_if0_ip_eth_type,
    output logic [3:0]           o_if0_ip_version,
    output logic [3:0]           o_if0_ip_ihl,
    output logic [5:0]           o_if0_ip_dscp,
    output logic [1:0]           o_if0_ip_ecn,
    output logic [15:0]          o_if0_ip_length,
    output logic [15:0]          o_if0_ip_identification,
    output logic [2:0]           o_if0_ip_flags,
    output logic [12:0]          o_if0_ip_fragment_offset,
    output logic [7:0]           o_if0_ip_ttl,
    output logic [7:0]           o_if0_ip_protocol,
    output logic [15:0]          o_if0_ip_header_checksum,
    output logic [31:0]          o_if0_ip_source_ip,
    output logic [31:0]          o_if0_ip_dest_ip,
    output logic [7:0]           o_if0_ip_payload_axis_tdata,
    output logic                 o_if0_ip_payload_axis_tvalid,
    output logic                 o_if0_ip_payload_axis_tlast,
    output logic                 o_if0_ip_payload_axis_tuser,
    input  logic                 o_if0_ip_payload_axis_tready,
    output logic                 o_if1_ip_hdr_valid,
    input  logic                 o_if1_ip_hdr_ready,
    output logic [47:0]          o_if1_ip_eth_dest_mac,
    output logic [47:0]          o_if1_ip_eth_src_mac,
    output logic [15:0]          o_if1_ip_eth_type,
    output logic [3:0]           o_if1_ip_version,
    output logic [3:0]           o_if1_ip_ihl,
    output logic [5:0]           o_if1_ip_dscp,
    output logic [1:0]           o_if1_ip_ecn,
    output logic [15:0]          o_if1_ip_length,
    output logic [15:0]          o_if1_ip_identification,
    output logic [2:0]           o_if1_ip_flags,
    output logic [12:0]          o_if1_ip_fragment_offset,
    output logic [7:0]           o_if1_ip_ttl,
    output logic [7:0]           o_if1_ip_protocol,
    output logic [15:0]          o_if1_ip_header_checksum,
    output logic [31:0]          o_if1_ip_source_ip,
    output logic [31:0]          o_if1_ip_dest_ip,
    output logic [7:0]           o_if1_ip_payload_axis_tdata,
    output logic                 o_if1_ip_payload_axis_tvalid,
    output logic                 o_if1_ip_payload_axis_tlast,
    output logic                 o_if1_ip_payload_axis_tuser,
    input  logic                 o_if1_ip_payload_axis_tready,
    output logic [CNT_WIDTH-1:0] o_pkt_cnt0,
    output logic [CNT_WIDTH-1:0] o_pkt_cnt1,
    output logic [CNT_WIDTH-1:0] o_err_cnt
);

    localparam int HDR_W = 272;

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;

    state_t           state, state_nxt;
    logic             sel;
    logic [HDR_W-1:0] hdr_in, hdr_q;
    logic             hdr_accept, pkt_done, pay_ready, in_hdr, in_pay;

    // All header fields travel as one flat word; both outputs share the registered copy.
    assign hdr_in = {i_ip_eth_dest_mac, i_ip_eth_src_mac, i_ip_eth_type, i_ip_version, i_ip_ihl,
                     i_ip_dscp, i_ip_ecn, i_ip_length, i_ip_identification, i_ip_flags,
                     i_ip_fragment_offset, i_ip_ttl, i_ip_protocol, i_ip_header_checksum,
                     i_ip_source_ip, i_ip_dest_ip};

    assign {o_if0_ip_eth_dest_mac, o_if0_ip_eth_src_mac, o_if0_ip_eth_type, o_if0_ip_version,
            o_if0_ip_ihl, o_if0_ip_dscp, o_if0_ip_ecn, o_if0_ip_length, o_if0_ip_identification,
            o_if0_ip_flags, o_if0_ip_fragment_offset, o_if0_ip_ttl, o_if0_ip_protocol,
            o_if0_ip_header_checksum, o_if0_ip_source_ip, o_if0_ip_dest_ip} = hdr_q;

    assign {o_if1_ip_eth_dest_mac, o_if1_ip_eth_src_mac, o_if1_ip_eth_type, o_if1_ip_version,
            o_if1_ip_ihl, o_if1_ip_dscp, o_if1_ip_ecn, o_if1_ip_length, o_if1_ip_identification,
            o_if1_ip_flags, o_if1_ip_fragment_offset, o_if1_ip_ttl, o_if1_ip_protocol,
            o_if1_ip_header_checksum, o_if1_ip_source_ip, o_if1_ip_dest_ip} = hdr_q;

    assign in_hdr    = (state == HDR);
    assign in_pay    = (state == PAYLOAD);
    assign pay_ready = sel ? o_if1_ip_payload_axis_tready : o_if0_ip_payload_axis_tready;

    // Ready is gated by reset directly so it drops without waiting for a clock edge.
    assign i_ip_hdr_ready           = rst && (state == IDLE);
    assign i_ip_payload_axis_tready = in_pay && pay_ready;

    assign o_if0_ip_hdr_valid = in_hdr && !sel;
    assign o_if1_ip_hdr_valid = in_hdr && sel;

    assign o_if0_ip_payload_axis_tvalid = in_pay && !sel && i_ip_payload_axis_tvalid;
    assign o_if1_ip_payload_axis_tvalid = in_pay && sel && i_ip_payload_axis_tvalid;
    assign o_if0_ip_payload_axis_tdata  = i_ip_payload_axis_tdata;
    assign o_if1_ip_payload_axis_tdata  = i_ip_payload_axis_tdata;
    assign o_if0_ip_payload_axis_tlast  = i_ip_payload_axis_tlast;
    assign o_if1_ip_payload_axis_tlast  = i_ip_payload_axis_tlast;
    assign o_if0_ip_payload_axis_tuser  = i_ip_payload_axis_tuser;
    assign o_if1_ip_payload_axis_tuser  = i_ip_payload_axis_tuser;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        hdr_accept = 1'b0;
        pkt_done   = 1'b0;
        case (state)
            IDLE: begin
                if (i_ip_hdr_valid) begin
                    hdr_accept = 1'b1;
                    state_nxt  = HDR;
                end
            end
            HDR: begin
                if (sel ? o_if1_ip_hdr_ready : o_if0_ip_hdr_ready) state_nxt = PAYLOAD;
            end
            PAYLOAD: begin
                if (i_ip_payload_axis_tvalid && pay_ready && i_ip_payload_axis_tlast) begin
                    pkt_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hdr_q      <= '0;
            sel        <= 1'b0;
            o_pkt_cnt0 <= '0;
            o_pkt_cnt1 <= '0;
            o_err_cnt  <= '0;
        end else begin
            if (hdr_accept) begin
                hdr_q <= hdr_in;
                sel   <= ((i_ip_dest_ip & ROUTE_MASK) == ROUTE_MATCH);
            end
            if (pkt_done) begin
                if (sel) o_pkt_cnt1 <= o_pkt_cnt1 + 1'b1;
                else     o_pkt_cnt0 <= o_pkt_cnt0 + 1'b1;
                if (i_ip_payload_axis_tuser) o_err_cnt <= o_err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_packet_dispatcher.sv
// Directed bench for packet_dispatcher: routing, header backpressure, payload throttling,
// error counting, asynchronous reset mid-packet and back-to-back packets.
module tb_packet_dispatcher;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        i_ip_hdr_valid, i_ip_hdr_ready;
    logic [47:0] i_ip_eth_dest_mac, i_ip_eth_src_mac;
    logic [15:0] i_ip_eth_type, i_ip_length, i_ip_identification, i_ip_header_checksum;
    logic [3:0]  i_ip_version, i_ip_ihl;
    logic [5:0]  i_ip_dscp;
    logic [1:0]  i_ip_ecn;
    logic [2:0]  i_ip_flags;
    logic [12:0] i_ip_fragment_offset;
    logic [7:0]  i_ip_ttl, i_ip_protocol;
    logic [31:0] i_ip_source_ip, i_ip_dest_ip;
    logic [7:0]  i_ip_payload_axis_tdata;
    logic        i_ip_payload_axis_tvalid, i_ip_payload_axis_tlast, i_ip_payload_axis_tuser;
    logic        i_ip_payload_axis_tready;

    logic        o_if0_ip_hdr_valid, o_if0_ip_hdr_ready, o_if1_ip_hdr_valid, o_if1_ip_hdr_ready;
    logic [47:0] o_if0_ip_eth_dest_mac, o_if0_ip_eth_src_mac, o_if1_ip_eth_dest_mac, o_if1_ip_eth_src_mac;
    logic [15:0] o_if0_ip_eth_type, o_if0_ip_length, o_if0_ip_identification, o_if0_ip_header_checksum;
    logic [15:0] o_if1_ip_eth_type, o_if1_ip_length, o_if1_ip_identification, o_if1_ip_header_checksum;
    logic [3:0]  o_if0_ip_version, o_if0_ip_ihl, o_if1_ip_version, o_if1_ip_ihl;
    logic [5:0]  o_if0_ip_dscp, o_if1_ip_dscp;
    logic [1:0]  o_if0_ip_ecn, o_if1_ip_ecn;
    logic [2:0]  o_if0_ip_flags, o_if1_ip_flags;
    logic [12:0] o_if0_ip_fragment_offset, o_if1_ip_fragment_offset;
    logic [7:0]  o_if0_ip_ttl, o_if0_ip_protocol, o_if1_ip_ttl, o_if1_ip_protocol;
    logic [31:0] o_if0_ip_source_ip, o_if0_ip_dest_ip, o_if1_ip_source_ip, o_if1_ip_dest_ip;
    logic [7:0]  o_if0_ip_payload_axis_tdata, o_if1_ip_payload_axis_tdata;
    logic        o_if0_ip_payload_axis_tvalid, o_if0_ip_payload_axis_tlast, o_if0_ip_payload_axis_tuser;
    logic        o_if1_ip_payload_axis_tvalid, o_if1_ip_payload_axis_tlast, o_if1_ip_payload_axis_tuser;
    logic        o_if0_ip_payload_axis_tready, o_if1_ip_payload_axis_tready;
    logic [31:0] o_pkt_cnt0, o_pkt_cnt1, o_err_cnt;

    packet_dispatcher dut (
        .clk(clk), .rst(rst),
        .i_ip_hdr_valid(i_ip_hdr_valid), .i_ip_hdr_ready(i_ip_hdr_ready),
        .i_ip_eth_dest_mac(i_ip_eth_dest_mac), .i_ip_eth_src_mac(i_ip_eth_src_mac),
        .i_ip_eth_type(i_ip_eth_type), .i_ip_version(i_ip_version), .i_ip_ihl(i_ip_ihl),
        .i_ip_dscp(i_ip_dscp), .i_ip_ecn(i_ip_ecn), .i_ip_length(i_ip_length),
        .i_ip_identification(i_ip_identification), .i_ip_flags(i_ip_flags),
        .i_ip_fragment_offset(i_ip_fragment_offset), .i_ip_ttl(i_ip_ttl), .i_ip_protocol(i_ip_protocol),
        .i_ip_header_checksum(i_ip_header_checksum), .i_ip_source_ip(i_ip_source_ip),
        .i_ip_dest_ip(i_ip_dest_ip),
        .i_ip_payload_axis_tdata(i_ip_payload_axis_tdata), .i_ip_payload_axis_tvalid(i_ip_payload_axis_tvalid),
        .i_ip_payload_axis_tlast(i_ip_payload_axis_tlast), .i_ip_payload_axis_tuser(i_ip_payload_axis_tuser),
        .i_ip_payload_axis_tready(i_ip_payload_axis_tready),
        .o_if0_ip_hdr_valid(o_if0_ip_hdr_valid), .o_if0_ip_hdr_ready(o_if0_ip_hdr_ready),
        .o_if0_ip_eth_dest_mac(o_if0_ip_eth_dest_mac), .o_if0_ip_eth_src_mac(o_if0_ip_eth_src_mac),
        .o_if0_ip_eth_type(o_if0_ip_eth_type), .o_if0_ip_version(o_if0_ip_version), .o_if0_ip_ihl(o_if0_ip_ihl),
        .o_if0_ip_dscp(o_if0_ip_dscp), .o_if0_ip_ecn(o_if0_ip_ecn), .o_if0_ip_length(o_if0_ip_length),
        .o_if0_ip_identification(o_if0_ip_identification), .o_if0_ip_flags(o_if0_ip_flags),
        .o_if0_ip_fragment_offset(o_if0_ip_fragment_offset), .o_if0_ip_ttl(o_if0_ip_ttl),
        .o_if0_ip_protocol(o_if0_ip_protocol), .o_if0_ip_header_checksum(o_if0_ip_header_checksum),
        .o_if0_ip_source_ip(o_if0_ip_source_ip), .o_if0_ip_dest_ip(o_if0_ip_dest_ip),
        .o_if0_ip_payload_axis_tdata(o_if0_ip_payload_axis_tdata),
        .o_if0_ip_payload_axis_tvalid(o_if0_ip_payload_axis_tvalid),
        .o_if0_ip_payload_axis_tlast(o_if0_ip_payload_axis_tlast),
        .o_if0_ip_payload_axis_tuser(o_if0_ip_payload_axis_tuser),
        .o_if0_ip_payload_axis_tready(o_if0_ip_payload_axis_tready),
        .o_if1_ip_hdr_valid(o_if1_ip_hdr_valid), .o_if1_ip_hdr_ready(o_if1_ip_hdr_ready),
        .o_if1_ip_eth_dest_mac(o_if1_ip_eth_dest_mac), .o_if1_ip_eth_src_mac(o_if1_ip_eth_src_mac),
        .o_if1_ip_eth_type(o_if1_ip_eth_type), .o_if1_ip_version(o_if1_ip_version), .o_if1_ip_ihl(o_if1_ip_ihl),
        .o_if1_ip_dscp(o_if1_ip_dscp), .o_if1_ip_ecn(o_if1_ip_ecn), .o_if1_ip_length(o_if1_ip_length),
        .o_if1_ip_identification(o_if1_ip_identification), .o_if1_ip_flags(o_if1_ip_flags),
        .o_if1_ip_fragment_offset(o_if1_ip_fragment_offset), .o_if1_ip_ttl(o_if1_ip_ttl),
        .o_if1_ip_protocol(o_if1_ip_protocol), .o_if1_ip_header_checksum(o_if1_ip_header_checksum),
        .o_if1_ip_source_ip(o_if1_ip_source_ip), .o_if1_ip_dest_ip(o_if1_ip_dest_ip),
        .o_if1_ip_payload_axis_tdata(o_if1_ip_payload_axis_tdata),
        .o_if1_ip_payload_axis_tvalid(o_if1_ip_payload_axis_tvalid),
        .o_if1_ip_payload_axis_tlast(o_if1_ip_payload_axis_tlast),
        .o_if1_ip_payload_axis_tuser(o_if1_ip_payload_axis_tuser),
        .o_if1_ip_payload_axis_tready(o_if1_ip_payload_axis_tready),
        .o_pkt_cnt0(o_pkt_cnt0), .o_pkt_cnt1(o_pkt_cnt1), .o_err_cnt(o_err_cnt)
    );

    logic [271:0] in_hdr, o0_hdr, o1_hdr, exp_hdr;
    assign in_hdr = {i_ip_eth_dest_mac, i_ip_eth_src_mac, i_ip_eth_type, i_ip_version, i_ip_ihl,
                     i_ip_dscp, i_ip_ecn, i_ip_length, i_ip_identification, i_ip_flags,
                     i_ip_fragment_offset, i_ip_ttl, i_ip_protocol, i_ip_header_checksum,
                     i_ip_source_ip, i_ip_dest_ip};
    assign o0_hdr = {o_if0_ip_eth_dest_mac, o_if0_ip_eth_src_mac, o_if0_ip_eth_type, o_if0_ip_version,
                     o_if0_ip_ihl, o_if0_ip_dscp, o_if0_ip_ecn, o_if0_ip_length, o_if0_ip_identification,
                     o_if0_ip_flags, o_if0_ip_fragment_offset, o_if0_ip_ttl, o_if0_ip_protocol,
                     o_if0_ip_header_checksum, o_if0_ip_source_ip, o_if0_ip_dest_ip};
    assign o1_hdr = {o_if1_ip_eth_dest_mac, o_if1_ip_eth_src_mac, o_if1_ip_eth_type, o_if1_ip_version,
                     o_if1_ip_ihl, o_if1_ip_dscp, o_if1_ip_ecn, o_if1_ip_length, o_if1_ip_identification,
                     o_if1_ip_flags, o_if1_ip_fragment_offset, o_if1_ip_ttl, o_if1_ip_protocol,
                     o_if1_ip_header_checksum, o_if1_ip_source_ip, o_if1_ip_dest_ip};

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk_w(input string tag, input logic [271:0] obs, input logic [271:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input logic [31:0] c0, input logic [31:0] c1, input logic [31:0] e);
        chk_w("pkt_cnt0", 272'(o_pkt_cnt0), 272'(c0));
        chk_w("pkt_cnt1", 272'(o_pkt_cnt1), 272'(c1));
        chk_w("err_cnt", 272'(o_err_cnt), 272'(e));
    endtask

    task automatic hdr_check(input logic s);
        chk_b("hdr_vld_sel", s ? o_if1_ip_hdr_valid : o_if0_ip_hdr_valid, 1'b1);
        chk_b("hdr_vld_oth", s ? o_if0_ip_hdr_valid : o_if1_ip_hdr_valid, 1'b0);
        chk_b("in_hdr_rdy_busy", i_ip_hdr_ready, 1'b0);
        chk_b("pay_rdy_in_hdr", i_ip_payload_axis_tready, 1'b0);
        chk_w("hdr_fields", s ? o1_hdr : o0_hdr, exp_hdr);
    endtask

    // Header phase: handshake in IDLE, then hold hdr_ready low for 'hold' cycles in HDR.
    task automatic start_pkt(input logic [31:0] dest, input logic s, input int hold);
        i_ip_dest_ip   = dest;
        i_ip_ttl       = i_ip_ttl + 8'd1;
        i_ip_hdr_valid = 1'b1;
        #1;
        chk_b("in_hdr_rdy_idle", i_ip_hdr_ready, 1'b1);
        exp_hdr = in_hdr;
        @(posedge clk); #1;
        i_ip_hdr_valid = 1'b0;
        i_ip_dest_ip   = ~dest;
        i_ip_ttl       = ~i_ip_ttl;
        if (hold > 0) begin
            if (s) o_if1_ip_hdr_ready = 1'b0;
            else   o_if0_ip_hdr_ready = 1'b0;
        end
        for (int k = 0; k < hold; k++) begin
            #1;
            hdr_check(s);
            @(posedge clk); #1;
        end
        o_if0_ip_hdr_ready = 1'b1;
        o_if1_ip_hdr_ready = 1'b1;
        #1;
        hdr_check(s);
        @(posedge clk); #1;
    endtask

    task automatic beat(input logic s, input logic [7:0] d, input logic last, input logic user);
        i_ip_payload_axis_tdata  = d;
        i_ip_payload_axis_tvalid = 1'b1;
        i_ip_payload_axis_tlast  = last;
        i_ip_payload_axis_tuser  = user;
        #1;
        chk_b("pay_vld_sel", s ? o_if1_ip_payload_axis_tvalid : o_if0_ip_payload_axis_tvalid, 1'b1);
        chk_b("pay_vld_oth", s ? o_if0_ip_payload_axis_tvalid : o_if1_ip_payload_axis_tvalid, 1'b0);
        chk_w("pay_data", 272'(s ? o_if1_ip_payload_axis_tdata : o_if0_ip_payload_axis_tdata), 272'(d));
        chk_b("pay_last", s ? o_if1_ip_payload_axis_tlast : o_if0_ip_payload_axis_tlast, last);
        chk_b("pay_rdy", i_ip_payload_axis_tready, 1'b1);
        @(posedge clk); #1;
        i_ip_payload_axis_tvalid = 1'b0;
        i_ip_payload_axis_tlast  = 1'b0;
        i_ip_payload_axis_tuser  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idx, cyc, rx;
        logic tg;
        rst = 1'b0;
        i_ip_hdr_valid = 1'b0;
        i_ip_eth_dest_mac = 48'h0011_2233_4455;
        i_ip_eth_src_mac  = 48'h6677_8899_AABB;
        i_ip_eth_type = 16'h0800; i_ip_version = 4'h4; i_ip_ihl = 4'h5; i_ip_dscp = 6'h2A;
        i_ip_ecn = 2'h1; i_ip_length = 16'h0020; i_ip_identification = 16'h1234; i_ip_flags = 3'h2;
        i_ip_fragment_offset = 13'h0ABC; i_ip_ttl = 8'h40; i_ip_protocol = 8'h11;
        i_ip_header_checksum = 16'hBEEF; i_ip_source_ip = 32'hC0A8_0002; i_ip_dest_ip = 32'h0;
        i_ip_payload_axis_tdata = 8'h00; i_ip_payload_axis_tvalid = 1'b0;
        i_ip_payload_axis_tlast = 1'b0; i_ip_payload_axis_tuser = 1'b0;
        o_if0_ip_hdr_ready = 1'b1; o_if1_ip_hdr_ready = 1'b1;
        o_if0_ip_payload_axis_tready = 1'b1; o_if1_ip_payload_axis_tready = 1'b1;
        exp_hdr = '0;

        // Reset state
        #1;
        chk_b("rst_in_hdr_rdy", i_ip_hdr_ready, 1'b0);
        chk_b("rst_in_pay_rdy", i_ip_payload_axis_tready, 1'b0);
        chk_b("rst_hdr_vld0", o_if0_ip_hdr_valid, 1'b0);
        chk_b("rst_hdr_vld1", o_if1_ip_hdr_valid, 1'b0);
        chk_w("rst_hdr_regs", o0_hdr, 272'(0));
        chk_cnt(0, 0, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk_b("post_rst_hdr_rdy", i_ip_hdr_ready, 1'b1);

        // Test 1: 10.0.0.5 -> if1, payload AA BB CC DD
        start_pkt(32'h0A00_0005, 1'b1, 0);
        beat(1'b1, 8'hAA, 1'b0, 1'b0);
        beat(1'b1, 8'hBB, 1'b0, 1'b0);
        beat(1'b1, 8'hCC, 1'b0, 1'b0);
        chk_cnt(0, 0, 0);
        beat(1'b1, 8'hDD, 1'b1, 1'b0);
        chk_cnt(0, 1, 0);

        // Test 2: 192.168.1.1 -> if0 with header backpressure for 5 clocks
        start_pkt(32'hC0A8_0101, 1'b0, 5);
        beat(1'b0, 8'h5A, 1'b1, 1'b0);
        chk_cnt(1, 1, 0);

        // Test 3: 16-byte payload to if0 with tready toggling 1,0,1,0...
        start_pkt(32'hC0A8_0101, 1'b0, 0);
        idx = 0; cyc = 0; rx = 0; tg = 1'b1;
        while (idx < 16 && cyc < 100) begin
            i_ip_payload_axis_tdata  = idx[7:0];
            i_ip_payload_axis_tvalid = 1'b1;
            i_ip_payload_axis_tlast  = (idx == 15);
            o_if0_ip_payload_axis_tready = tg;
            #1;
            chk_b("thr_in_rdy", i_ip_payload_axis_tready, tg);
            chk_b("thr_vld0", o_if0_ip_payload_axis_tvalid, 1'b1);
            chk_b("thr_vld1", o_if1_ip_payload_axis_tvalid, 1'b0);
            if (tg) begin
                chk_w("thr_order", 272'(o_if0_ip_payload_axis_tdata), 272'(rx));
                rx++;
            end
            @(posedge clk); #1;
            if (tg) idx++;
            tg = ~tg;
            cyc++;
        end
        i_ip_payload_axis_tvalid = 1'b0;
        i_ip_payload_axis_tlast  = 1'b0;
        o_if0_ip_payload_axis_tready = 1'b1;
        #1;
        chk_w("thr_beats", 272'(rx), 272'(16));
        chk_b("thr_back_idle", i_ip_hdr_ready, 1'b1);
        chk_cnt(2, 1, 0);

        // Test 4: tuser on tlast -> error count and if1 packet count
        start_pkt(32'h0A00_0009, 1'b1, 0);
        beat(1'b1, 8'h01, 1'b0, 1'b1);
        chk_cnt(2, 1, 0);
        beat(1'b1, 8'h02, 1'b1, 1'b1);
        chk_cnt(2, 2, 1);

        // Test 5: asynchronous reset during beat 3 of an 8-byte payload
        start_pkt(32'h0A00_0011, 1'b1, 0);
        beat(1'b1, 8'h10, 1'b0, 1'b0);
        beat(1'b1, 8'h11, 1'b0, 1'b0);
        beat(1'b1, 8'h12, 1'b0, 1'b0);
        i_ip_payload_axis_tdata  = 8'h13;
        i_ip_payload_axis_tvalid = 1'b1;
        #1;
        chk_b("b3_vld1", o_if1_ip_payload_axis_tvalid, 1'b1);
        rst = 1'b0;
        #1;
        chk_b("arst_vld1", o_if1_ip_payload_axis_tvalid, 1'b0);
        chk_b("arst_vld0", o_if0_ip_payload_axis_tvalid, 1'b0);
        chk_b("arst_pay_rdy", i_ip_payload_axis_tready, 1'b0);
        chk_b("arst_hdr_rdy", i_ip_hdr_ready, 1'b0);
        chk_b("arst_hdr_vld1", o_if1_ip_hdr_valid, 1'b0);
        chk_cnt(0, 0, 0);
        @(posedge clk); #1;
        i_ip_payload_axis_tvalid = 1'b0;
        rst = 1'b1;
        #1;
        chk_b("rel_idle", i_ip_hdr_ready, 1'b1);
        chk_cnt(0, 0, 0);

        // Test 6: back-to-back alternating single-beat packets, mask boundaries
        start_pkt(32'h0A00_0100, 1'b0, 0);
        beat(1'b0, 8'hA0, 1'b1, 1'b0);
        start_pkt(32'h0A00_00FF, 1'b1, 0);
        beat(1'b1, 8'hA1, 1'b1, 1'b0);
        start_pkt(32'hC0A8_0101, 1'b0, 0);
        beat(1'b0, 8'hA2, 1'b1, 1'b0);
        start_pkt(32'h0A00_0000, 1'b1, 0);
        beat(1'b1, 8'hA3, 1'b1, 1'b0);
        chk_cnt(2, 2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
